// File: rtl/ioctl_pkg.sv
// Shared types and helpers for the HPS ioctl download router.
package ioctl_pkg;

    localparam int IOCTL_AW    = 27;
    localparam int MAX_REGIONS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } region_sel_t;

    // Highest region whose base is <= addr; no hit below region 0 or at/after rom_end.
    function automatic region_sel_t region_sel(
        input logic [IOCTL_AW-1:0]             addr,
        input logic [MAX_REGIONS*IOCTL_AW-1:0] bases,
        input int                              num,
        input logic [IOCTL_AW-1:0]             rom_end
    );
        region_sel_t r;
        r = '0;
        for (int i = 0; i < MAX_REGIONS; i++) begin
            if (i < num && addr >= bases[i*IOCTL_AW +: IOCTL_AW]) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        if (addr >= rom_end) begin
            r.hit = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [IOCTL_AW-1:0] region_base(
        input logic [MAX_REGIONS*IOCTL_AW-1:0] bases,
        input logic [2:0]                      idx
    );
        return bases[idx*IOCTL_AW +: IOCTL_AW];
    endfunction

endpackage

// File: rtl/ioctl_loader_region_dec.sv
// Combinational ROM region decoder: picks the region for one byte address and
// produces the one-hot write select and the region-local address.
module ioctl_region_dec
    import ioctl_pkg::*;
#(
    parameter int                              NUM_REGIONS = 4,
    parameter int                              ADDR_W      = 17,
    parameter logic [NUM_REGIONS*IOCTL_AW-1:0] REGION_BASE = {27'h18000, 27'h10000, 27'h08000, 27'h0},
    parameter logic [IOCTL_AW-1:0]             ROM_END     = 27'h20000
) (
    input  logic [IOCTL_AW-1:0]    byte_addr,
    output logic                   hit,
    output logic [NUM_REGIONS-1:0] region_oh,
    output logic [ADDR_W-1:0]      local_addr
);

    // Widen the base table so the shared helper can use a fixed width.
    localparam logic [MAX_REGIONS*IOCTL_AW-1:0] BASES = (MAX_REGIONS*IOCTL_AW)'(REGION_BASE);

    region_sel_t sel;

    // Base compare and subtract for the byte currently being emitted.
    always_comb begin
        sel        = region_sel(byte_addr, BASES, NUM_REGIONS, ROM_END);
        hit        = sel.hit;
        region_oh  = sel.hit ? (NUM_REGIONS'(1) << sel.idx) : '0;
        local_addr = ADDR_W'(byte_addr - region_base(BASES, sel.idx));
    end

endmodule

// File: rtl/ioctl_loader.sv
// HPS download router: splits each 16-bit ioctl word into two byte writes,
// routes ROM bytes to address-decoded regions and DIP bytes to a switch bank,
// and tracks ROM load completion for the core hold-reset.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for ioctl_wr or a pending ROM download end
//  ST_LO    | low byte (even address) on the outputs, ioctl_wait high
//  ST_HI    | high byte (odd address) on the outputs, ioctl_wait high
//  ST_FLUSH | one cycle: rom_loaded set, load_done pulsing
//
// Byte outputs are registered on the edge that enters LO/HI, so what is
// visible during a state is that state's byte.
module ioctl_loader
    import ioctl_pkg::*;
#(
    parameter int                              NUM_REGIONS = 4,
    parameter int                              ADDR_W      = 17,
    parameter logic [NUM_REGIONS*IOCTL_AW-1:0] REGION_BASE = {27'h18000, 27'h10000, 27'h08000, 27'h0},
    parameter logic [IOCTL_AW-1:0]             ROM_END     = 27'h20000,
    parameter logic [7:0]                      ROM_INDEX   = 8'd0,
    parameter logic [7:0]                      DIP_INDEX   = 8'd254,
    parameter int                              DIP_BYTES   = 8,
    parameter logic [DIP_BYTES*8-1:0]          DIP_DEFAULT = '0
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [IOCTL_AW-1:0]    ioctl_addr,
    input  logic [15:0]            ioctl_dout,
    output logic                   ioctl_wait,
    output logic [NUM_REGIONS-1:0] rom_we,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [7:0]             rom_data,
    output logic [DIP_BYTES*8-1:0] dip_sw,
    output logic                   core_reset,
    output logic                   rom_loaded,
    output logic                   load_done,
    output logic                   overrun
);

    state_t                   state_q, state_d;
    logic                     wait_q, wait_d;
    logic [NUM_REGIONS-1:0]   rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [7:0]               rom_data_q, rom_data_d;
    logic [DIP_BYTES*8-1:0]   dip_q, dip_d;
    logic                     loaded_q, loaded_d;
    logic                     done_q, done_d;
    logic                     overrun_q, overrun_d;
    logic [IOCTL_AW-2:0]      word_addr_q, word_addr_d;
    logic [7:0]               word_hi_q, word_hi_d;
    logic [7:0]               word_idx_q, word_idx_d;
    logic                     dl_q, dl_d;
    logic [7:0]               dl_idx_q, dl_idx_d;
    logic                     end_pend_q, end_pend_d;

    logic                     emit;
    logic [IOCTL_AW-1:0]      emit_addr;
    logic [7:0]               emit_byte;
    logic [7:0]               emit_idx;
    logic                     dec_hit;
    logic [NUM_REGIONS-1:0]   dec_oh;
    logic [ADDR_W-1:0]        dec_local;
    logic                     dl_fall;
    logic                     dl_rise_rom;

    // Address bit 0 is implied by which half of the word is being emitted.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ioctl_addr[0];

    // Download edges; the end is qualified by the index seen while the download was active.
    assign dl_fall     = dl_q & ~ioctl_download & (dl_idx_q == ROM_INDEX);
    assign dl_rise_rom = ~dl_q & ioctl_download & (ioctl_index == ROM_INDEX);

    // Select the byte to present next: low byte straight off the bus on accept, high byte from the latch in LO.
    always_comb begin
        emit      = 1'b0;
        emit_addr = '0;
        emit_byte = '0;
        emit_idx  = '0;
        if (state_q == ST_IDLE && ioctl_wr) begin
            emit      = 1'b1;
            emit_addr = {ioctl_addr[IOCTL_AW-1:1], 1'b0};
            emit_byte = ioctl_dout[7:0];
            emit_idx  = ioctl_index;
        end else if (state_q == ST_LO) begin
            emit      = 1'b1;
            emit_addr = {word_addr_q, 1'b1};
            emit_byte = word_hi_q;
            emit_idx  = word_idx_q;
        end
    end

    ioctl_region_dec #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .ROM_END     (ROM_END)
    ) u_region_dec (
        .byte_addr  (emit_addr),
        .hit        (dec_hit),
        .region_oh  (dec_oh),
        .local_addr (dec_local)
    );

    // Next-state, byte routing and flag logic.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        rom_we_d    = '0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        dip_d       = dip_q;
        loaded_d    = loaded_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        word_addr_d = word_addr_q;
        word_hi_d   = word_hi_q;
        word_idx_d  = word_idx_q;
        dl_d        = ioctl_download;
        dl_idx_d    = ioctl_download ? ioctl_index : dl_idx_q;
        end_pend_d  = end_pend_q | dl_fall;

        case (state_q)
            ST_IDLE: begin
                if (ioctl_wr) begin
                    word_addr_d = ioctl_addr[IOCTL_AW-1:1];
                    word_hi_d   = ioctl_dout[15:8];
                    word_idx_d  = ioctl_index;
                    wait_d      = 1'b1;
                    state_d     = ST_LO;
                end else if (end_pend_d) begin
                    end_pend_d = 1'b0;
                    loaded_d   = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_FLUSH;
                end
            end
            ST_LO: begin
                overrun_d = overrun_q | ioctl_wr;
                state_d   = ST_HI;
            end
            ST_HI: begin
                overrun_d = overrun_q | ioctl_wr;
                wait_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_FLUSH: begin
                overrun_d = overrun_q | ioctl_wr;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (dl_rise_rom) begin
            loaded_d = 1'b0;
        end

        if (emit) begin
            if (emit_idx == ROM_INDEX) begin
                if (dec_hit) begin
                    rom_we_d   = dec_oh;
                    rom_addr_d = dec_local;
                    rom_data_d = emit_byte;
                end
            end else if (emit_idx == DIP_INDEX) begin
                for (int k = 0; k < DIP_BYTES; k++) begin
                    if (emit_addr == IOCTL_AW'(k)) begin
                        dip_d[8*k +: 8] = emit_byte;
                    end
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= 1'b0;
            rom_we_q    <= '0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
            dip_q       <= DIP_DEFAULT;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            word_addr_q <= '0;
            word_hi_q   <= '0;
            word_idx_q  <= '0;
            dl_q        <= 1'b0;
            dl_idx_q    <= '0;
            end_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
            dip_q       <= dip_d;
            loaded_q    <= loaded_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            word_addr_q <= word_addr_d;
            word_hi_q   <= word_hi_d;
            word_idx_q  <= word_idx_d;
            dl_q        <= dl_d;
            dl_idx_q    <= dl_idx_d;
            end_pend_q  <= end_pend_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign dip_sw     = dip_q;
    assign rom_loaded = loaded_q;
    assign load_done  = done_q;
    assign overrun    = overrun_q;
    // The core stays held while a ROM download is running or until one has completed.
    assign core_reset = ~loaded_q | (ioctl_download & (ioctl_index == ROM_INDEX));

endmodule

// File: tb/tb_ioctl_loader.sv
// Bench for ioctl_loader: drives ioctl words, predicts ROM byte writes into a
// queue that a monitor drains as strobes appear, and tracks the DIP bank.
module tb_ioctl_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic [3:0]  rom_we;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [63:0] dip_sw;
    logic        core_reset;
    logic        rom_loaded;
    logic        load_done;
    logic        overrun;

    ioctl_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .dip_sw         (dip_sw),
        .core_reset     (core_reset),
        .rom_loaded     (rom_loaded),
        .load_done      (load_done),
        .overrun        (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [3:0]  we;
        logic [16:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  dip_m[8];
    int unsigned base_m[4] = '{32'h0, 32'h8000, 32'h10000, 32'h18000};
    int          total = 0;
    int          bad = 0;
    int          ld_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [63:0] dip_pack();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = dip_m[k];
        return r;
    endfunction

    // Reference: where a single byte should land.
    task automatic model_byte(input logic [7:0] idx, input int unsigned b, input logic [7:0] d);
        exp_t e;
        int   r = -1;
        if (idx == 8'd0) begin
            for (int i = 0; i < 4; i++) if (b >= base_m[i]) r = i;
            if (b < 32'h20000 && r >= 0) begin
                e.we = 4'(1 << r);
                e.a  = 17'(b - base_m[r]);
                e.d  = d;
                exp_q.push_back(e);
            end
        end else if (idx == 8'd254 && b < 8) begin
            dip_m[b] = d;
        end
    endtask

    // Present a word strobe (caller is at a negedge) and predict both bytes.
    task automatic issue(input logic [7:0] idx, input logic [26:0] addr, input logic [15:0] dout);
        int unsigned b;
        b = {5'd0, addr[26:1], 1'b0};
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = dout;
        ioctl_wr    = 1'b1;
        model_byte(idx, b, dout[7:0]);
        model_byte(idx, b + 1, dout[15:8]);
    endtask

    task automatic send(input logic [7:0] idx, input logic [26:0] addr, input logic [15:0] dout);
        issue(idx, addr, dout);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        check("wait_lo", 64'(ioctl_wait), 64'd1);
        @(negedge clk_sys);
        check("wait_hi", 64'(ioctl_wait), 64'd1);
        @(negedge clk_sys);
        check("wait_idle", 64'(ioctl_wait), 64'd0);
        check("dip_bank", dip_sw, dip_pack());
    endtask

    // Monitor: every strobe must match the oldest predicted byte.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (load_done) ld_cnt++;
            if (rom_we != 4'd0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rom_unexpected: got we=%b addr=%h data=%h want no strobe",
                             rom_we, rom_addr, rom_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rom_we !== e.we || rom_addr !== e.a || rom_data !== e.d) begin
                        bad++;
                        $display("FAIL rom_byte: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                                 rom_we, rom_addr, rom_data, e.we, e.a, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [26:0] ra;
        logic [7:0]  ri;
        for (int k = 0; k < 8; k++) dip_m[k] = 8'h00;

        repeat (3) @(negedge clk_sys);
        check("rst_we",      64'(rom_we), 64'd0);
        check("rst_addr",    64'(rom_addr), 64'd0);
        check("rst_data",    64'(rom_data), 64'd0);
        check("rst_wait",    64'(ioctl_wait), 64'd0);
        check("rst_dip",     dip_sw, 64'd0);
        check("rst_core",    64'(core_reset), 64'd1);
        check("rst_loaded",  64'(rom_loaded), 64'd0);
        check("rst_done",    64'(load_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // ROM download: directed words then random traffic
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        @(negedge clk_sys);
        check("core_rst_dl", 64'(core_reset), 64'd1);
        send(8'd0, 27'h08002, 16'hBEEF);
        send(8'd0, 27'h20000, 16'h1234);
        send(8'd0, 27'h00005, 16'h5678);
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       ri = 8'd254;
                1:       ri = 8'd3;
                default: ri = 8'd0;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 27'($urandom_range(0, 11));
            else ra = 27'($urandom_range(0, 32'h21000));
            send(ri, ra, 16'($urandom));
        end

        // DIP bank directed writes
        send(8'd254, 27'd2, 16'h3412);
        check("dip_b2", 64'(dip_sw[23:16]), 64'h12);
        check("dip_b3", 64'(dip_sw[31:24]), 64'h34);
        send(8'd254, 27'd8, 16'hFFFF);

        // Download end arriving while the high byte is out
        issue(8'd0, 27'h18100, 16'($urandom));
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        check("loaded_pre_end", 64'(rom_loaded), 64'd0);
        repeat (6) @(negedge clk_sys);
        check("done_pulses_1", 64'(ld_cnt), 64'd1);
        check("loaded_set",    64'(rom_loaded), 64'd1);
        check("core_rst_low",  64'(core_reset), 64'd0);

        // DIP download leaves load state alone
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        send(8'd254, 27'd5, 16'h7788);
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("dip_no_done",   64'(ld_cnt), 64'd1);
        check("dip_loaded",    64'(rom_loaded), 64'd1);
        check("dip_core_rst",  64'(core_reset), 64'd0);

        // New ROM download re-arms the hold
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("redl_core_rst", 64'(core_reset), 64'd1);
        check("redl_loaded",   64'(rom_loaded), 64'd0);

        // Overrun: second strobe one cycle after the first is dropped
        check("overrun_pre", 64'(overrun), 64'd0);
        issue(8'd0, 27'h08010, 16'hC3A5);
        @(negedge clk_sys);
        ioctl_addr = 27'h08020;
        ioctl_dout = 16'h6699;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("overrun_set", 64'(overrun), 64'd1);
        repeat (2) @(negedge clk_sys);
        check("overrun_sticky", 64'(overrun), 64'd1);

        // End this ROM download from idle
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("done_pulses_2", 64'(ld_cnt), 64'd2);
        check("loaded_2",      64'(rom_loaded), 64'd1);

        // Reset while the low byte is out: high byte never appears
        ioctl_index = 8'd0;
        ioctl_addr  = 27'h10010;
        ioctl_dout  = 16'hA55A;
        ioctl_wr    = 1'b1;
        model_byte(8'd0, 32'h10010, 8'h5A);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        reset_n  = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) dip_m[k] = 8'h00;
        check("mid_rst_we",      64'(rom_we), 64'd0);
        check("mid_rst_addr",    64'(rom_addr), 64'd0);
        check("mid_rst_data",    64'(rom_data), 64'd0);
        check("mid_rst_wait",    64'(ioctl_wait), 64'd0);
        check("mid_rst_dip",     dip_sw, dip_pack());
        check("mid_rst_core",    64'(core_reset), 64'd1);
        check("mid_rst_loaded",  64'(rom_loaded), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_pulses_end", 64'(ld_cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
